core_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the core control/decode path. It issues word reads to the instruction bus and buffers returned words in a 2-entry prefetch queue. It presents the oldest instruction and its word address to decode, and holds them while the core stalls. On a taken branch it flushes the queue, discards any in-flight response and restarts fetching at the branch target.

---
 rtl/core_fetch.sv | 100 ++++++++++
 tb/tb_core_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch.sv
// Instruction fetch stage: single-outstanding word reads into a 2-entry
// prefetch queue, head held under stall, flush and redirect on branch.
module core_fetch #(
    parameter logic [31:0] NOP_INSN = 32'hE1A00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch,
    input  logic [29:0] branch_target,
    input  logic        fetch_ready,
    input  logic [31:0] fetch_data,
    output logic        fetch,
    output logic [29:0] fetch_addr,
    output logic [31:0] insn,
    output logic [29:0] insn_pc,
    output logic        insn_valid
);

    typedef struct packed {
        logic [31:0] word;
        logic [29:0] pc;
    } entry_t;

    entry_t     head;
    entry_t     tail;
    entry_t     new_entry;
    logic [1:0] count;
    logic       pending;
    logic       discard;

    logic       pop;
    logic       push;
    logic [1:0] count_after_pop;

    assign insn_valid = (count != 2'd0);
    assign insn       = insn_valid ? head.word : NOP_INSN;
    assign insn_pc    = head.pc;
    assign new_entry  = {fetch_data, fetch_addr};

    // Issue looks at the occupancy after this cycle's pop, so a request can
    // go out in the same cycle a full queue drains one entry.
    always_comb begin
        pop             = insn_valid && !stall && !branch;
        push            = fetch_ready && !discard && !branch;
        count_after_pop = count - {1'b0, insn_valid && !stall};
        fetch           = rst_n && !pending && !branch && (count_after_pop < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (branch) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= new_entry;
                    else               tail <= new_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= new_entry;
                    end else begin
                        head <= tail;
                        tail <= new_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    // A branch with a response still in flight marks it stale; a response
    // landing in the branch cycle itself is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr <= '0;
            pending    <= 1'b0;
            discard    <= 1'b0;
        end else if (branch) begin
            fetch_addr <= branch_target;
            pending    <= pending && !fetch_ready;
            discard    <= pending && !fetch_ready;
        end else begin
            if (fetch)            pending <= 1'b1;
            else if (fetch_ready) pending <= 1'b0;
            if (fetch_ready)      discard <= 1'b0;
            if (push)             fetch_addr <= fetch_addr + 30'd1;
        end
    end

endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch: queue-level reference model checked every
// cycle, plus literal expectations for latency, ordering, flush and wrap.
module tb_core_fetch;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [29:0] branch_target = '0;
    logic        fetch_ready = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        fetch;
    logic [29:0] fetch_addr;
    logic [31:0] insn;
    logic [29:0] insn_pc;
    logic        insn_valid;

    core_fetch #(.NOP_INSN(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch),
        .branch_target(branch_target), .fetch_ready(fetch_ready),
        .fetch_data(fetch_data), .fetch(fetch), .fetch_addr(fetch_addr),
        .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [29:0] pc;
    } ent_t;

    // reference model
    ent_t        mq[$];
    logic [29:0] m_addr;
    logic        m_pend, m_disc;

    // bus responder
    int          lat;
    logic        b_busy;
    int          b_wait;
    logic [29:0] b_addr;

    // stimulus
    logic        s_stall, s_branch;
    logic [29:0] s_target;

    int          cyc, checks, errors;

    // observations since the last mark
    int          mark_cyc, f_cyc, v_cyc, rdy_cnt;
    logic        got_f, got_v;
    logic [29:0] f_addr, v_pc;
    logic [31:0] v_insn;
    logic [29:0] fa[$];
    logic [29:0] pops[$];
    logic        smp_fetch, smp_valid;
    logic [29:0] smp_fa, smp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for bus state (cycle %0d)", name, cyc);
    endtask

    task automatic mark();
        mark_cyc = cyc;
        got_f = 1'b0;
        got_v = 1'b0;
        rdy_cnt = 0;
        fa.delete();
        pops.delete();
    endtask

    task automatic step();
        logic        exp_fetch, pop, s_rdy;
        logic [31:0] s_data;
        int          n_after;
        ent_t        e;
        @(negedge clk);
        cyc++;
        stall         = s_stall;
        branch        = s_branch;
        branch_target = s_target;
        fetch_ready   = b_busy && (b_wait == 0);
        fetch_data    = {b_addr, 2'b00};
        #1;
        pop       = (mq.size() > 0) && !stall;
        n_after   = mq.size() - (pop ? 1 : 0);
        exp_fetch = !m_pend && !branch && (n_after < 2);
        chk("insn_valid", 32'(insn_valid), 32'(mq.size() > 0));
        chk("insn", insn, (mq.size() > 0) ? mq[0].word : NOP);
        if (mq.size() > 0) chk("insn_pc", 32'(insn_pc), 32'(mq[0].pc));
        chk("fetch", 32'(fetch), 32'(exp_fetch));
        chk("fetch_addr", 32'(fetch_addr), 32'(m_addr));

        smp_fetch = fetch;
        smp_fa    = fetch_addr;
        smp_valid = insn_valid;
        smp_pc    = insn_pc;
        s_rdy     = fetch_ready;
        s_data    = fetch_data;
        if (smp_fetch) begin
            fa.push_back(smp_fa);
            if (!got_f) begin
                got_f = 1'b1; f_cyc = cyc; f_addr = smp_fa;
            end
        end
        if (s_rdy && !got_f) rdy_cnt++;
        if (insn_valid && !got_v) begin
            got_v = 1'b1; v_cyc = cyc; v_pc = insn_pc; v_insn = insn;
        end
        if (insn_valid && !stall && !branch) pops.push_back(insn_pc);

        @(posedge clk);
        if (branch) begin
            mq.delete();
            m_addr = branch_target;
            m_disc = m_pend && !s_rdy;
            m_pend = m_pend && !s_rdy;
        end else begin
            if (pop) mq.delete(0);
            if (s_rdy) begin
                m_pend = 1'b0;
                if (m_disc) begin
                    m_disc = 1'b0;
                end else begin
                    e.word = s_data;
                    e.pc   = m_addr;
                    mq.push_back(e);
                    m_addr = m_addr + 30'd1;
                end
            end
            if (exp_fetch) m_pend = 1'b1;
        end
        if (s_rdy) b_busy = 1'b0;
        if (smp_fetch) begin
            b_busy = 1'b1; b_wait = lat - 1; b_addr = smp_fa;
        end else if (b_busy && b_wait > 0) begin
            b_wait--;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_insn_valid", 32'(insn_valid), 32'd0);
        chk("rst_insn", insn, NOP);
        chk("rst_fetch", 32'(fetch), 32'd0);
        chk("rst_fetch_addr", 32'(fetch_addr), 32'd0);
        chk("rst_insn_pc", 32'(insn_pc), 32'd0);
        mq.delete();
        m_addr = '0; m_pend = 1'b0; m_disc = 1'b0;
        b_busy = 1'b0; b_wait = 0; b_addr = '0;
        fetch_ready = 1'b0; branch = 1'b0; s_branch = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0; lat = 1;
        s_stall = 1'b0; s_branch = 1'b0; s_target = '0;
        m_addr = '0; m_pend = 1'b0; m_disc = 1'b0;
        b_busy = 1'b0; b_wait = 0; b_addr = '0;

        // reset release, zero-wait bus
        do_reset();
        mark();
        repeat (12) step();
        chk("t1_first_fetch_cyc", 32'(f_cyc), 32'd1);
        chk("t1_first_fetch_addr", 32'(f_addr), 32'd0);
        chk("t1_first_valid_cyc", 32'(v_cyc), 32'd3);
        chk("t1_first_insn", v_insn, 32'd0);
        chk("t1_first_pc", 32'(v_pc), 32'd0);
        chk("t1_npops", 32'(pops.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < pops.size(); i++) chk("t1_pop_pc", 32'(pops[i]), 32'(i));

        // stall: queue fills to 2, head held at pc 5
        mark();
        s_stall = 1'b1;
        repeat (10) begin
            step();
            chk("t2_head_valid", 32'(smp_valid), 32'd1);
            chk("t2_head_pc", 32'(smp_pc), 32'd5);
        end
        chk("t2_fetches_in_stall", 32'(fa.size()), 32'd1);
        if (fa.size() > 0) chk("t2_stall_fetch_addr", 32'(fa[0]), 32'd6);
        s_stall = 1'b0;
        mark();
        repeat (8) step();
        chk("t2_npops", 32'(pops.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < pops.size(); i++) chk("t2_pop_pc", 32'(pops[i]), 32'(5 + i));

        // branch while request to 5 pending on a 3-cycle bus
        do_reset();
        lat = 3;
        n = 0;
        do begin step(); n++; end while (!(smp_fetch && smp_fa == 30'd5) && n < 80);
        if (n >= 80) timeout_fail("t3_wait_fetch5");
        s_branch = 1'b1; s_target = 30'h100;
        step();
        s_branch = 1'b0;
        mark();
        repeat (10) step();
        chk("t3_dropped_rsp", 32'(rdy_cnt), 32'd1);
        chk("t3_fetch_addr", 32'(f_addr), 32'h100);
        chk("t3_fetch_delay", 32'(f_cyc - mark_cyc), 32'd3);
        chk("t3_first_pc", 32'(v_pc), 32'h100);
        chk("t3_first_valid_delay", 32'(v_cyc - mark_cyc), 32'd7);

        // branch in the same cycle as a response
        lat = 2;
        n = 0;
        while (!(b_busy && b_wait == 0) && n < 40) begin step(); n++; end
        if (n >= 40) timeout_fail("t4_wait_ready");
        s_branch = 1'b1; s_target = 30'h200;
        step();
        s_branch = 1'b0;
        mark();
        repeat (6) step();
        chk("t4_fetch_delay", 32'(f_cyc - mark_cyc), 32'd1);
        chk("t4_fetch_addr", 32'(f_addr), 32'h200);
        chk("t4_first_pc", 32'(v_pc), 32'h200);
        chk("t4_first_valid_delay", 32'(v_cyc - mark_cyc), 32'd4);

        // two back-to-back branches over one outstanding request
        lat = 3;
        n = 0;
        while (!(b_busy && b_wait == 2) && n < 40) begin step(); n++; end
        if (n >= 40) timeout_fail("t5_wait_issue");
        s_branch = 1'b1; s_target = 30'h40;
        step();
        s_target = 30'h80;
        step();
        s_branch = 1'b0;
        mark();
        repeat (10) step();
        chk("t5_dropped_rsp", 32'(rdy_cnt), 32'd1);
        chk("t5_fetch_delay", 32'(f_cyc - mark_cyc), 32'd2);
        chk("t5_fetch_addr", 32'(f_addr), 32'h80);
        chk("t5_first_pc", 32'(v_pc), 32'h80);

        // address wrap
        lat = 1;
        s_branch = 1'b1; s_target = 30'h3FFFFFFF;
        step();
        s_branch = 1'b0;
        mark();
        repeat (12) step();
        chk("t6_nfetch", 32'(fa.size() >= 2), 32'd1);
        if (fa.size() >= 2) begin
            chk("t6_fetch0", 32'(fa[0]), 32'h3FFFFFFF);
            chk("t6_fetch1", 32'(fa[1]), 32'd0);
        end
        chk("t6_npops", 32'(pops.size() >= 2), 32'd1);
        if (pops.size() >= 2) begin
            chk("t6_pop0", 32'(pops[0]), 32'h3FFFFFFF);
            chk("t6_pop1", 32'(pops[1]), 32'd0);
        end

        // asynchronous reset mid-stream
        s_stall = 1'b1;
        repeat (4) step();
        chk("t7_prerst_valid", 32'(smp_valid), 32'd1);
        s_stall = 1'b0;
        do_reset();
        mark();
        repeat (6) step();
        chk("t7_fetch_cyc", 32'(f_cyc), 32'd1);
        chk("t7_fetch_addr", 32'(f_addr), 32'd0);
        chk("t7_valid_cyc", 32'(v_cyc), 32'd3);
        chk("t7_first_pc", 32'(v_pc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
